aes_final_round_pipe: RTL and testbench

AES_FINAL_ROUND_PIPE -- requirements
Module: aes_final_round_pipe

---
 rtl/aes_pkg.sv | 62 ++++++
 rtl/aes_sub_shift.sv | 39 +++
 rtl/aes_final_round_pipe.sv | 108 ++++++++++
 tb/tb_aes_final_round_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES helpers: GF(2^8) arithmetic, S-box functions and state byte indexing.
// Inverse S-box functions are compiled only with AES_INV_CIPHER_EN.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;

    // Byte idx = 4*col + row; byte 0 occupies the top byte of the block.
    function automatic int unsigned state_idx(input int unsigned row, input int unsigned col);
        return 4 * col + row;
    endfunction

    function automatic int unsigned byte_msb(input int unsigned idx);
        return AES_BLOCK_W - 1 - 8 * idx;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = '0;
        aa = a;
        bb = b;
        for (int unsigned i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // a^254 = a^2 * a^4 * ... * a^128, which is the field inverse (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int unsigned i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]} ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        return aff_fwd(gf_inv(x));
    endfunction

`ifdef AES_INV_CIPHER_EN
    function automatic logic [7:0] aff_inv(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] x);
        return gf_inv(aff_inv(x));
    endfunction
`endif

endpackage

// File: rtl/aes_sub_shift.sv
// Combinational SubBytes+ShiftRows; with AES_INV_CIPHER_EN also the inverse
// pair, selected per block by inv_i.
module aes_sub_shift
    import aes_pkg::*;
(
    input  logic [AES_BLOCK_W-1:0] state_i,
`ifdef AES_INV_CIPHER_EN
    input  logic                   inv_i,
`endif
    output logic [AES_BLOCK_W-1:0] state_o
);

    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int unsigned DST   = byte_msb(state_idx(r, c));
            localparam int unsigned SRC_F = byte_msb(state_idx(r, (c + r) % 4));
            logic [7:0] out_b;
`ifdef AES_INV_CIPHER_EN
            localparam int unsigned SRC_I = byte_msb(state_idx(r, (c + 4 - r) % 4));
            logic [7:0] src_b;
            logic [7:0] pre_b;
            logic [7:0] inv_b;
            // Forward and inverse S-box share one field inverter per byte.
            always_comb begin
                src_b = inv_i ? state_i[SRC_I -: 8] : state_i[SRC_F -: 8];
                pre_b = inv_i ? aff_inv(src_b) : src_b;
                inv_b = gf_inv(pre_b);
                out_b = inv_i ? inv_b : aff_fwd(inv_b);
            end
`else
            always_comb begin
                out_b = sbox_fwd(state_i[SRC_F -: 8]);
            end
`endif
            assign state_o[DST -: 8] = out_b;
        end
    end

endmodule

// File: rtl/aes_final_round_pipe.sv
// AES final round (no MixColumns) behind an elastic valid/ready pipeline.
// Optional inverse cipher path: define AES_INV_CIPHER_EN.
module aes_final_round_pipe
    import aes_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 3,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    input  logic [AES_BLOCK_W-1:0] in_key,
    input  logic [TAG_W-1:0]       in_tag,
`ifdef AES_INV_CIPHER_EN
    input  logic                   in_inv,
`endif
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    logic [AES_BLOCK_W-1:0] sub_shift;
    logic [AES_BLOCK_W-1:0] round_out;
    logic [PIPE_DEPTH-1:0]  vld_all;

    aes_sub_shift u_sub_shift (
        .state_i (in_data),
`ifdef AES_INV_CIPHER_EN
        .inv_i   (in_inv),
`endif
        .state_o (sub_shift)
    );

    // The whole round is resolved before stage 0, so key and mode never need storing.
    always_comb begin
        round_out = sub_shift ^ in_key;
    end

    for (genvar i = 0; i < PIPE_DEPTH; i++) begin : g_stg
        logic                   vld_q, vld_d;
        logic [AES_BLOCK_W-1:0] dat_q, dat_d;
        logic [TAG_W-1:0]       tag_q, tag_d;
        logic                   rdy;
        logic                   nxt_rdy;
        logic                   prv_vld;
        logic [AES_BLOCK_W-1:0] prv_dat;
        logic [TAG_W-1:0]       prv_tag;

        if (i == 0) begin : g_head
            always_comb begin
                prv_vld = in_valid;
                prv_dat = round_out;
                prv_tag = in_tag;
            end
        end else begin : g_body
            always_comb begin
                prv_vld = g_stg[i-1].vld_q;
                prv_dat = g_stg[i-1].dat_q;
                prv_tag = g_stg[i-1].tag_q;
            end
        end

        if (i == PIPE_DEPTH - 1) begin : g_tail
            always_comb nxt_rdy = out_ready;
        end else begin : g_link
            always_comb nxt_rdy = g_stg[i+1].rdy;
        end

        // A stage accepts when empty or when its own block moves on this cycle.
        always_comb begin
            rdy   = !vld_q || nxt_rdy;
            vld_d = rdy ? prv_vld : vld_q;
            dat_d = dat_q;
            tag_d = tag_q;
            if (rdy && prv_vld) begin
                dat_d = prv_dat;
                tag_d = prv_tag;
            end
        end

        always_ff @(posedge clk) begin
            if (!reset) begin
                vld_q <= 1'b0;
                dat_q <= '0;
                tag_q <= '0;
            end else begin
                vld_q <= vld_d;
                dat_q <= dat_d;
                tag_q <= tag_d;
            end
        end

        assign vld_all[i] = vld_q;
    end

    always_comb begin
        in_ready  = reset && g_stg[0].rdy;
        out_valid = g_stg[PIPE_DEPTH-1].vld_q;
        out_data  = g_stg[PIPE_DEPTH-1].dat_q;
        out_tag   = g_stg[PIPE_DEPTH-1].tag_q;
        busy      = |vld_all;
    end

endmodule

// File: tb/tb_aes_final_round_pipe.sv
// Directed and randomized-stream bench for aes_final_round_pipe, checked by
// immediate assertions against a table-driven reference model.
module tb_aes_final_round_pipe;

    localparam int unsigned D  = 3;
    localparam int unsigned TW = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [127:0]   in_data;
    logic [127:0]   in_key;
    logic [TW-1:0]  in_tag;
    logic           in_inv;
    logic           out_valid;
    logic           out_ready;
    logic [127:0]   out_data;
    logic [TW-1:0]  out_tag;
    logic           busy;

    int total = 0;
    int bad   = 0;

    logic [7:0]     sbox_t  [256];
    logic [7:0]     isbox_t [256];
    logic [2047:0]  sbox_flat;

    logic [127:0]   exp_q [$];
    logic [TW-1:0]  exp_tq [$];
    logic           held;
    logic [127:0]   held_data;
    logic [TW-1:0]  held_tag;
    int             n_acc;
    int             n_emit;
    int             cyc;
    int             first_emit;
    int             last_emit;

    always #5 clk = ~clk;

    aes_final_round_pipe #(
        .PIPE_DEPTH (D),
        .TAG_W      (TW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_tag    (in_tag),
`ifdef AES_INV_CIPHER_EN
        .in_inv    (in_inv),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .busy      (busy)
    );

    task automatic check_w(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_n(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic [127:0] k, input logic inv);
        logic [127:0] res;
        logic [127:0] t;
        logic [7:0]   b;
        int           src;
        res = '0;
        for (int idx = 0; idx < 16; idx++) begin
            int r;
            int c;
            r = idx % 4;
            c = idx / 4;
            src = inv ? (4 * ((c - r + 4) % 4) + r) : (4 * ((c + r) % 4) + r);
            t = d >> (8 * (15 - src));
            b = t[7:0];
            res = {res[119:0], (inv ? isbox_t[b] : sbox_t[b])};
        end
        return res ^ k;
    endfunction

    // One clock cycle: drive at the falling edge, then observe what the next rising edge will transfer.
    task automatic step(input logic iv, input logic [127:0] d, input logic [127:0] k,
                        input logic [TW-1:0] t, input logic inv, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        in_key    = k;
        in_tag    = t;
        in_inv    = inv;
        out_ready = ordy;
        #1;
        if (held) begin
            check_n("hold_valid", int'(out_valid), 1);
            check_w("hold_data", out_data, held_data);
            check_n("hold_tag", int'(out_tag), int'(held_tag));
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(model(d, k, inv));
            exp_tq.push_back(t);
            n_acc++;
        end
        if (out_valid && out_ready) begin
            check_n("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
            if (exp_q.size() > 0) begin
                check_w("stream_data", out_data, exp_q.pop_front());
                check_n("stream_tag", int'(out_tag), int'(exp_tq.pop_front()));
            end
            if (n_emit == 0) first_emit = cyc;
            last_emit = cyc;
            n_emit++;
        end
        held      = out_valid && !out_ready;
        held_data = out_data;
        held_tag  = out_tag;
        cyc++;
    endtask

    task automatic latency(input string name, input logic [127:0] d, input logic [127:0] k,
                           input logic [TW-1:0] t, input logic inv, input logic [127:0] exp_d);
        int n;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_key    = k;
        in_tag    = t;
        in_inv    = inv;
        out_ready = 1'b1;
        #1;
        check_n({name, "_in_ready"}, int'(in_ready), 1);
        n = 0;
        for (int w = 0; w < 20; w++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (n == 1) begin
                in_valid = 1'b0;
                in_key   = 128'hdeadbeef_0badf00d_cafef00d_12345678;
            end
            #1;
            if (out_valid) break;
        end
        check_n({name, "_latency"}, n, D);
        check_w({name, "_data"}, out_data, exp_d);
        check_n({name, "_tag"}, int'(out_tag), int'(t));
    endtask

    initial begin
        sbox_flat = {
            128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
            128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
            128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
            128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
            128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
            128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
            128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
            128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_flat[2047 - 8 * i -: 8];
        for (int i = 0; i < 256; i++) begin
            logic [7:0] ii;
            ii = i[7:0];
            isbox_t[sbox_t[ii]] = ii;
        end

        reset = 1'b0; in_valid = 1'b0; in_data = '0; in_key = '0; in_tag = '0;
        in_inv = 1'b0; out_ready = 1'b1; held = 1'b0; held_data = '0; held_tag = '0;
        n_acc = 0; n_emit = 0; cyc = 0; first_emit = -1; last_emit = -1;

        @(negedge clk);
        @(negedge clk);
        #1;
        check_n("rst_in_ready", int'(in_ready), 0);
        check_n("rst_out_valid", int'(out_valid), 0);
        check_n("rst_busy", int'(busy), 0);
        check_w("rst_out_data", out_data, '0);
        check_n("rst_out_tag", int'(out_tag), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_n("post_rst_in_ready", int'(in_ready), 1);

        latency("zero", '0, '0, 4'h3, 1'b0, {16{8'h63}});
        latency("ones_key", '0, '1, 4'h5, 1'b0, {16{8'h9c}});
        latency("shiftrows", 128'h00010000_00000000_00000000_00000000, '0, 4'ha, 1'b0,
                128'h63636363_63636363_63636363_637c6363);
`ifdef AES_INV_CIPHER_EN
        latency("inv_zero", '0, '0, 4'h6, 1'b1, {16{8'h52}});
        latency("fwd_52", {16{8'h52}}, '0, 4'h7, 1'b0, '0);
        step(1'b1, '0, '0, 4'h1, 1'b1, 1'b1);
        step(1'b1, {16{8'h52}}, '0, 4'h2, 1'b0, 1'b1);
        step(1'b1, 128'h00112233_44556677_8899aabb_ccddeeff, '1, 4'h3, 1'b1, 1'b1);
        for (int g = 0; g < 20 && exp_q.size() > 0; g++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        check_n("alt_drained", exp_q.size(), 0);
`endif

        n_acc = 0;
        for (int g = 0; g < 2000 && n_acc < 32; g++) begin
            logic inv_r;
`ifdef AES_INV_CIPHER_EN
            inv_r = 1'($urandom_range(0, 1));
`else
            inv_r = 1'b0;
`endif
            step(1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, TW'($urandom), inv_r,
                 1'($urandom_range(0, 1)));
        end
        check_n("stream_accepted", n_acc, 32);
        for (int g = 0; g < 100 && exp_q.size() > 0; g++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        check_n("stream_drained", exp_q.size(), 0);

        n_acc = 0; n_emit = 0; cyc = 0; first_emit = -1; last_emit = -1;
        for (int j = 0; j < 16 + int'(D) + 1; j++)
            step(j < 16, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                 TW'(j), 1'b0, 1'b1);
        check_n("fullrate_acc", n_acc, 16);
        check_n("fullrate_emit", n_emit, 16);
        check_n("fullrate_first", first_emit, D);
        check_n("fullrate_last", last_emit, D + 15);

        for (int j = 0; j < int'(D) + 2; j++)
            step(1'b1, {$urandom, $urandom, $urandom, $urandom}, '0, TW'(j), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check_n("full_busy", int'(busy), 1);
        check_n("full_out_valid", int'(out_valid), 1);
        check_n("full_in_ready", int'(in_ready), 0);
        reset = 1'b0;
        in_valid = 1'b0;
        #1;
        check_n("rst_pulse_in_ready", int'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_n("rst_pulse_out_valid", int'(out_valid), 0);
        check_n("rst_pulse_busy", int'(busy), 0);
        check_w("rst_pulse_out_data", out_data, '0);
        check_n("rst_pulse_in_ready_rel", int'(in_ready), 1);
        exp_q.delete();
        exp_tq.delete();
        held = 1'b0;
        n_emit = 0;
        for (int j = 0; j < 8; j++) step(1'b0, '0, '0, '0, 1'b0, 1'b1);
        check_n("no_stale_emit", n_emit, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
